// File: rtl/small_div_if.sv
`default_nettype none
// ============================================================================
// Module      : small_div_if
// Description : Dividend/result bundle for the constant divider.
// Revision    : 1.0
// ============================================================================
interface small_div_if #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVIDER_WIDTH  = 3
);
    logic                      enable;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVIDER_WIDTH-1:0]  remainder;

    modport master (output enable, output dividend, input quotient, input remainder);
    modport slave  (input enable, input dividend, output quotient, output remainder);
endinterface
`default_nettype wire

// File: rtl/small_div.sv
`default_nettype none
// ============================================================================
// Module      : small_div
// Description : Pipelined unsigned division by an elaboration-time constant,
//               long division in radix 2^C digits with one LUT-sized step each.
// Revision    : 1.0
// ============================================================================
module small_div #(
    parameter int DIVIDER_VALUE         = 5,
    parameter int DIVIDER_WIDTH         = $clog2(DIVIDER_VALUE),
    parameter int DIVIDEND_WIDTH        = 18,
    parameter int THEORETICAL_LUT_WIDTH = 6,
    parameter int REGISTER_IN           = 1,
    parameter int REGISTER_OUT          = 1,
    parameter int PIPELINE              = 1
) (
    input  wire logic  clock,
    input  wire logic  reset,
    small_div_if.slave bus
);
    localparam int c_chunk_w = THEORETICAL_LUT_WIDTH - DIVIDER_WIDTH;
    localparam int c_steps   = (DIVIDEND_WIDTH + c_chunk_w - 1) / c_chunk_w;
    localparam int c_ext_w   = c_steps * c_chunk_w;
    localparam bit c_reg_in  = (PIPELINE != 0) && (REGISTER_IN != 0);
    localparam bit c_reg_out = (PIPELINE != 0) && (REGISTER_OUT != 0);
    localparam logic [THEORETICAL_LUT_WIDTH-1:0] c_div =
        THEORETICAL_LUT_WIDTH'(DIVIDER_VALUE);

    logic [DIVIDEND_WIDTH-1:0] w_div_in;
    logic [c_ext_w-1:0]        w_ext;
    logic [DIVIDER_WIDTH-1:0]  w_rem   [c_steps+1];
    logic [c_chunk_w-1:0]      w_digit [c_steps];
    logic [c_ext_w-1:0]        w_quo_ext;
    logic [DIVIDEND_WIDTH-1:0] w_quo;

    // ---------------------------------------------------------------- input
    generate
        if (c_reg_in) begin : g_in_reg
            logic [DIVIDEND_WIDTH-1:0] dividend_q, dividend_d;

            always_comb begin
                dividend_d = dividend_q;
                if (bus.enable) dividend_d = bus.dividend;
            end

            always_ff @(posedge clock) begin
                if (reset) dividend_q <= '0;
                else       dividend_q <= dividend_d;
            end

            assign w_div_in = dividend_q;
        end else begin : g_in_comb
            assign w_div_in = bus.dividend;
        end
    endgenerate

    // ------------------------------------------------------- division steps
    assign w_ext    = c_ext_w'(w_div_in);
    assign w_rem[0] = '0;

    generate
        for (genvar k = 0; k < c_steps; k++) begin : g_step
            logic [THEORETICAL_LUT_WIDTH-1:0] w_t;
            // Running remainder is < D, so each digit fits in one chunk width.
            assign w_t        = {w_rem[k], w_ext[c_ext_w-1-k*c_chunk_w -: c_chunk_w]};
            assign w_digit[k] = c_chunk_w'(w_t / c_div);
            assign w_rem[k+1] = DIVIDER_WIDTH'(w_t % c_div);
        end
    endgenerate

    always_comb begin
        w_quo_ext = '0;
        for (int k = 0; k < c_steps; k++) begin
            w_quo_ext[c_ext_w-1-k*c_chunk_w -: c_chunk_w] = w_digit[k];
        end
    end

    assign w_quo = DIVIDEND_WIDTH'(w_quo_ext);

    // --------------------------------------------------------------- output
    generate
        if (c_reg_out) begin : g_out_reg
            logic [DIVIDEND_WIDTH-1:0] quotient_q, quotient_d;
            logic [DIVIDER_WIDTH-1:0]  remainder_q, remainder_d;

            always_comb begin
                quotient_d  = quotient_q;
                remainder_d = remainder_q;
                if (bus.enable) begin
                    quotient_d  = w_quo;
                    remainder_d = w_rem[c_steps];
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    quotient_q  <= '0;
                    remainder_q <= '0;
                end else begin
                    quotient_q  <= quotient_d;
                    remainder_q <= remainder_d;
                end
            end

            assign bus.quotient  = quotient_q;
            assign bus.remainder = remainder_q;
        end else begin : g_out_comb
            assign bus.quotient  = w_quo;
            assign bus.remainder = w_rem[c_steps];
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_small_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_small_div
// Description : Randomized self-checking bench for small_div in three configs.
// Revision    : 1.0
// ============================================================================
module tb_small_div;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // A: defaults (D=5, W=18, latency 2)
    small_div_if #(.DIVIDEND_WIDTH(18), .DIVIDER_WIDTH(3)) if_a ();
    small_div u_a (.clock(clock), .reset(reset), .bus(if_a));

    // B: combinational, D=3, W=8
    small_div_if #(.DIVIDEND_WIDTH(8), .DIVIDER_WIDTH(2)) if_b ();
    small_div #(
        .DIVIDER_VALUE(3), .DIVIDEND_WIDTH(8), .THEORETICAL_LUT_WIDTH(6), .PIPELINE(0)
    ) u_b (.clock(clock), .reset(reset), .bus(if_b));

    // C: D=4, LUT width 4 (C=2), W=10, latency 2
    small_div_if #(.DIVIDEND_WIDTH(10), .DIVIDER_WIDTH(2)) if_c ();
    small_div #(
        .DIVIDER_VALUE(4), .DIVIDEND_WIDTH(10), .THEORETICAL_LUT_WIDTH(4)
    ) u_c (.clock(clock), .reset(reset), .bus(if_c));

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: values sampled at enabled edges, oldest first; output is f(front).
    int qa[$];
    int qc[$];
    int cnt_c = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int a_in, input bit en, input bit rst, input int b_in);
        reset         = rst;
        if_a.enable   = en;
        if_a.dividend = a_in[17:0];
        if_c.enable   = en;
        if_c.dividend = cnt_c[9:0];
        if_b.enable   = en;
        if_b.dividend = b_in[7:0];
        @(posedge clock);
        if (rst) begin
            qa = '{0, 0};
            qc = '{0, 0};
        end else if (en) begin
            qa.push_back(a_in & 32'h3FFFF);
            void'(qa.pop_front());
            qc.push_back(cnt_c & 32'h3FF);
            void'(qc.pop_front());
        end
        cnt_c++;
        #1;
        chk_eq("a_quo", 32'(if_a.quotient),  qa[0] / 5);
        chk_eq("a_rem", 32'(if_a.remainder), qa[0] % 5);
        chk_eq("c_quo", 32'(if_c.quotient),  qc[0] / 4);
        chk_eq("c_rem", 32'(if_c.remainder), qc[0] % 4);
        chk_eq("b_quo", 32'(if_b.quotient),  (b_in & 255) / 3);
        chk_eq("b_rem", 32'(if_b.remainder), (b_in & 255) % 3);
    endtask

    initial begin
        int n;
        if_a.enable = 1'b0; if_a.dividend = '0;
        if_b.enable = 1'b0; if_b.dividend = '0;
        if_c.enable = 1'b0; if_c.dividend = '0;
        qa = '{0, 0};
        qc = '{0, 0};

        step(0, 1'b0, 1'b1, 255);
        step(0, 1'b1, 1'b1, 7);

        n = 0;
        for (int i = 0; i < 300; i++) begin
            step(n, 1'b1, 1'b0, int'($urandom_range(255)));
            n++;
        end
        for (int i = 0; i < 3; i++)
            step(int'($urandom), 1'b0, 1'b0, int'($urandom_range(255)));
        for (int i = 0; i < 50; i++) begin
            step(n, 1'b1, 1'b0, int'($urandom_range(255)));
            n++;
        end

        // Top of range and wrap to zero
        n = 262135;
        for (int i = 0; i < 16; i++) begin
            step(n, 1'b1, 1'b0, 0);
            n = (n + 1) & 32'h3FFFF;
        end

        // Reset while 1000 is in flight, then a clean 1000
        step(1000, 1'b1, 1'b0, 1);
        step(2000, 1'b1, 1'b1, 2);
        step(1000, 1'b1, 1'b0, 3);
        step(4, 1'b1, 1'b0, 4);
        step(5, 1'b1, 1'b0, 5);

        for (int i = 0; i < 3000; i++) begin
            step(int'($urandom), ($urandom_range(3) != 0), ($urandom_range(199) == 0),
                 int'($urandom_range(255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
